// File: rtl/audio_pkt_sched.sv
// Ping-pong packet scheduler: packs 16-bit samples into two alternating banks and serves each full bank to the UDP engine byte by byte.
// Latency: last sample write -> tx_start after 2 cycles; tx_req -> tx_data 1 cycle later; tx_done -> bank free 2 cycles later.
// Backpressure: none toward the sample source; while both banks are occupied new samples are dropped and counted in ovf_cnt.
module audio_pkt_sched #(
    parameter int SAMPLES_PER_PKT = 256,
    parameter int DATA_WIDTH      = 16,
    parameter int TIMEOUT_CYC     = 1_000_000
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  eth_ready,
    input  logic                  enable,
    input  logic                  smp_vld,
    input  logic [DATA_WIDTH-1:0] smp_data,
    output logic                  tx_start,
    output logic [15:0]           tx_byte_num,
    input  logic                  tx_req,
    output logic [7:0]            tx_data,
    input  logic                  tx_done,
    output logic                  tx_timeout,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           ovf_cnt
);
    localparam int N   = SAMPLES_PER_PKT;
    localparam int PW  = $clog2(N);
    localparam int MAW = $clog2(2 * N);
    localparam int BIW = $clog2(2 * N) + 1;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_RELEASE} state_t;

    // Both banks share one RAM: bank 0 at [0, N), bank 1 at [N, 2N)
    logic [DATA_WIDTH-1:0] r_mem [2*N];

    logic [1:0]     r_full;
    logic           r_wr_bank;
    logic [PW-1:0]  r_wr_ptr;
    logic           r_stall;
    logic [15:0]    r_ovf_cnt;

    state_t         r_state;
    logic           r_rd_bank;
    logic [BIW-1:0] r_byte_idx;
    logic [TW-1:0]  r_to_cnt;
    logic           r_tx_start;
    logic           r_tx_timeout;
    logic [7:0]     r_tx_data;
    logic [15:0]    r_pkt_cnt;

    logic                  w_acc;
    logic                  w_drop;
    logic                  w_last;
    logic                  w_to;
    logic                  w_release;
    logic                  w_other_free;
    logic                  w_byte_ok;
    logic [MAW-1:0]        w_waddr;
    logic [MAW-1:0]        w_raddr;
    logic [BIW-2:0]        w_sidx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_acc  = enable & smp_vld & ~r_stall;
    assign w_drop = enable & smp_vld & r_stall;
    assign w_last = w_acc && (r_wr_ptr == PW'(N - 1));

    // tx_done wins over a timeout landing in the same cycle
    assign w_to = ((r_state == S_START) || ((r_state == S_SEND) && !tx_done))
                  && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // A bank is handed back either by the RELEASE state or by an abandoned packet
    assign w_release = (r_state == S_RELEASE) || w_to;

    // The other bank counts as free if it is being released this very cycle
    assign w_other_free = !r_full[~r_wr_bank] || (w_release && (r_rd_bank != r_wr_bank));

    assign w_byte_ok = (r_byte_idx < BIW'(2 * N));
    assign w_sidx    = r_byte_idx[BIW-1:1];
    assign w_waddr   = r_wr_bank ? (MAW'(N) + MAW'(r_wr_ptr)) : MAW'(r_wr_ptr);
    assign w_raddr   = r_rd_bank ? (MAW'(N) + MAW'(w_sidx)) : MAW'(w_sidx);
    assign w_rd_word = r_mem[w_raddr];

    // Sample storage write port
    always_ff @(posedge sys_clk) begin
        if (w_acc) begin
            r_mem[w_waddr] <= smp_data;
        end
    end

    // Write side: fill pointer, bank toggle, stall, full flags and overflow count
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
            r_stall   <= 1'b0;
            r_ovf_cnt <= 16'h0000;
        end else begin
            if (w_acc) begin
                if (w_last) begin
                    r_wr_ptr <= '0;
                    if (w_other_free) begin
                        r_wr_bank <= ~r_wr_bank;
                    end else begin
                        r_stall <= 1'b1;
                    end
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end else if (r_stall && w_release) begin
                r_stall   <= 1'b0;
                r_wr_bank <= ~r_wr_bank;
            end
            for (int b = 0; b < 2; b++) begin
                if (w_last && (r_wr_bank == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_release && (r_rd_bank == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
            if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    // Send FSM: pick a full bank, announce it, stream bytes on request, release on done or timeout
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rd_bank    <= 1'b0;
            r_byte_idx   <= '0;
            r_to_cnt     <= '0;
            r_tx_start   <= 1'b0;
            r_tx_timeout <= 1'b0;
            r_tx_data    <= 8'h00;
            r_pkt_cnt    <= 16'h0000;
        end else begin
            r_tx_start   <= 1'b0;
            r_tx_timeout <= 1'b0;
            if (tx_req) begin
                if ((r_state == S_SEND) && w_byte_ok) begin
                    r_tx_data <= r_byte_idx[0] ? w_rd_word[7:0] : w_rd_word[15:8];
                end else begin
                    r_tx_data <= 8'h00;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (eth_ready && (|r_full)) begin
                        // With both banks full the older one is the bank not being written
                        r_rd_bank  <= (&r_full) ? ~r_wr_bank : r_full[1];
                        r_tx_start <= 1'b1;
                        r_to_cnt   <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_byte_idx <= '0;
                    r_to_cnt   <= r_to_cnt + 1'b1;
                    if (w_to) begin
                        r_tx_timeout <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (tx_req && w_byte_ok) begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                    end
                    if (tx_done) begin
                        r_state <= S_RELEASE;
                    end else if (w_to) begin
                        r_tx_timeout <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_timeout  = r_tx_timeout;
    assign tx_data     = r_tx_data;
    assign tx_byte_num = 16'(2 * SAMPLES_PER_PKT);
    assign pkt_cnt     = r_pkt_cnt;
    assign ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_audio_pkt_sched.sv
// Testbench for audio_pkt_sched with 4-sample packets and a 100-cycle timeout.
// Table of packets checks byte order and start latency; directed sequences cover overflow, same-cycle release, timeout, eth_ready gating and reset.
module tb_audio_pkt_sched;
    logic        sys_clk;
    logic        rst_n;
    logic        eth_ready;
    logic        enable;
    logic        smp_vld;
    logic [15:0] smp_data;
    logic        tx_start;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        tx_timeout;
    logic [15:0] pkt_cnt;
    logic [15:0] ovf_cnt;

    audio_pkt_sched #(
        .SAMPLES_PER_PKT (4),
        .DATA_WIDTH      (16),
        .TIMEOUT_CYC     (100)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .eth_ready   (eth_ready),
        .enable      (enable),
        .smp_vld     (smp_vld),
        .smp_data    (smp_data),
        .tx_start    (tx_start),
        .tx_byte_num (tx_byte_num),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .tx_timeout  (tx_timeout),
        .pkt_cnt     (pkt_cnt),
        .ovf_cnt     (ovf_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int exp_pkt = 0;
    int starts_used = 0;

    // Event monitor sampled on the falling edge
    int cyc = 0;
    int start_cnt = 0;
    int to_cnt = 0;
    int last_start_cyc = 0;
    int last_to_cyc = 0;
    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (tx_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            last_start_cyc = cyc;
        end
        if (tx_timeout === 1'b1) begin
            to_cnt = to_cnt + 1;
            last_to_cyc = cyc;
        end
    end

    typedef struct {
        logic [63:0] smp;
        logic [63:0] bytes;
    } vec_t;
    vec_t tbl [3];

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic feed(input logic [15:0] v);
        smp_vld  = 1'b1;
        smp_data = v;
        tick;
        smp_vld  = 1'b0;
    endtask

    function automatic logic [15:0] sv(input int k);
        logic [7:0] kb;
        kb = k[7:0];
        return {kb, 8'hA0 + kb};
    endfunction

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        while (start_cnt == starts_used && n < 60) begin
            tick;
            n++;
        end
        checks++;
        if (start_cnt == starts_used) begin
            errors++;
            $display("FAIL %s_start: no tx_start within %0d cycles", nm, n);
        end else begin
            starts_used = starts_used + 1;
        end
    endtask

    // Request 10 bytes: 8 payload bytes MSB first, then two past the end that read as zero
    task automatic read_bytes(input logic [63:0] exp, input string nm);
        logic [7:0] eb;
        for (int i = 0; i < 10; i++) begin
            tx_req = 1'b1;
            tick;
            eb = (i < 8) ? exp[63-8*i -: 8] : 8'h00;
            chk($sformatf("%s_byte%0d", nm, i), tx_data, eb);
        end
        tx_req = 1'b0;
    endtask

    task automatic read_pkt(input logic [63:0] exp, input string nm);
        wait_start(nm);
        read_bytes(exp, nm);
    endtask

    task automatic finish_pkt(input string nm);
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        tick;
        exp_pkt++;
        chk($sformatf("%s_pkt_cnt", nm), pkt_cnt, exp_pkt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        int sc;
        int s0;
        int seen;
        int n;

        tbl[0].smp = 64'h1234_5678_9ABC_DEF0; tbl[0].bytes = 64'h12_34_56_78_9A_BC_DE_F0;
        tbl[1].smp = 64'h0000_FFFF_00FF_FF00; tbl[1].bytes = 64'h00_00_FF_FF_00_FF_FF_00;
        tbl[2].smp = 64'hA55A_0001_8000_7FFE; tbl[2].bytes = 64'hA5_5A_00_01_80_00_7F_FE;

        rst_n = 1'b0; eth_ready = 1'b1; enable = 1'b1; smp_vld = 1'b0; smp_data = 16'h0;
        tx_req = 1'b0; tx_done = 1'b0;
        tick; tick;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_timeout", tx_timeout, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("tx_byte_num", tx_byte_num, 16'd8);
        rst_n = 1'b1;
        tick;

        // Table: start two cycles after the last strobe, bytes MSB first, pkt_cnt counts
        for (int t = 0; t < 3; t++) begin
            for (int j = 0; j < 4; j++) feed(tbl[t].smp[63-16*j -: 16]);
            chk($sformatf("v%0d_start_t1", t), tx_start, 0);
            tick;
            chk($sformatf("v%0d_start_t2", t), tx_start, 1);
            tick;
            chk($sformatf("v%0d_start_pulse", t), tx_start, 0);
            read_pkt(tbl[t].bytes, $sformatf("v%0d", t));
            finish_pkt($sformatf("v%0d", t));
        end
        chk("tbl_ovf", ovf_cnt, 0);

        // Overflow: 8 samples fill both banks, 9..11 dropped, disabled strobe not counted
        for (int k = 1; k <= 11; k++) feed(sv(k));
        enable = 1'b0;
        feed(16'hDEAD);
        enable = 1'b1;
        chk("ovf_cnt3", ovf_cnt, 3);
        read_pkt({sv(1), sv(2), sv(3), sv(4)}, "ovf_p1");
        finish_pkt("ovf_p1");
        for (int k = 12; k <= 15; k++) feed(sv(k));
        read_pkt({sv(5), sv(6), sv(7), sv(8)}, "ovf_p2");
        finish_pkt("ovf_p2");
        read_pkt({sv(12), sv(13), sv(14), sv(15)}, "ovf_p3");
        finish_pkt("ovf_p3");
        chk("ovf_after", ovf_cnt, 3);

        // Timeout: abandoned packet after 100 cycles, next full bank then goes out
        feed(16'hF00D); feed(16'hBEEF); feed(16'hCAFE); feed(16'hD00D);
        feed(16'h0102); feed(16'h0304); feed(16'h0506); feed(16'h0708);
        wait_start("to_p1");
        sc = last_start_cyc;
        n = 0;
        while (to_cnt == 0 && n < 150) begin
            tick;
            n++;
        end
        chk("to_seen", to_cnt, 1);
        chk("to_delay", last_to_cyc - sc, 100);
        chk("to_pkt_cnt", pkt_cnt, exp_pkt);
        read_pkt(64'h0102_0304_0506_0708, "to_p2");
        finish_pkt("to_p2");
        chk("to_count_once", to_cnt, 1);
        chk("to_ovf", ovf_cnt, 3);

        // Fill completion in the same cycle as the other bank's release
        feed(16'h1001); feed(16'h2002); feed(16'h3003); feed(16'h4004);
        feed(16'h5A5A); feed(16'h6B6B); feed(16'h7C7C);
        read_pkt(64'h1001_2002_3003_4004, "same_a");
        tx_done = 1'b1;
        tick;
        tx_done  = 1'b0;
        smp_vld  = 1'b1;
        smp_data = 16'h8D8D;
        tick;
        smp_vld = 1'b0;
        exp_pkt++;
        chk("same_pkt_cnt", pkt_cnt, exp_pkt);
        feed(16'hE001); feed(16'hE002); feed(16'hE003); feed(16'hE004);
        chk("same_ovf", ovf_cnt, 3);
        read_pkt(64'h5A5A_6B6B_7C7C_8D8D, "same_b");
        finish_pkt("same_b");
        read_pkt(64'hE001_E002_E003_E004, "same_c");
        finish_pkt("same_c");

        // eth_ready gating, then a packet that survives eth_ready dropping mid-send
        eth_ready = 1'b0;
        feed(16'h0F1E); feed(16'h2D3C); feed(16'h4B5A); feed(16'h6978);
        repeat (20) tick;
        chk("rdy_no_start", start_cnt, starts_used);
        eth_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick;
            if (tx_start) seen = 1;
        end
        chk("rdy_start_2cyc", seen, 1);
        wait_start("rdy");
        eth_ready = 1'b0;
        read_bytes(64'h0F1E_2D3C_4B5A_6978, "rdy");
        finish_pkt("rdy");
        eth_ready = 1'b1;

        // Reset in the middle of SEND after three bytes
        feed(16'h1357); feed(16'h2468); feed(16'hACE0); feed(16'hBDF1);
        wait_start("rst");
        for (int i = 0; i < 3; i++) begin
            tx_req = 1'b1;
            tick;
            v = 64'h1357_2468_ACE0_BDF1;
            chk($sformatf("rst_pre_byte%0d", i), tx_data, v[63-8*i -: 8]);
        end
        tx_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_mid_tx_data", tx_data, 8'h00);
        chk("rst_mid_pkt_cnt", pkt_cnt, 0);
        chk("rst_mid_ovf_cnt", ovf_cnt, 0);
        chk("rst_mid_tx_start", tx_start, 0);
        chk("rst_mid_tx_timeout", tx_timeout, 0);
        exp_pkt = 0;
        tick;
        rst_n = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            tx_req = 1'b1;
            tick;
            chk($sformatf("rst_post_byte%0d", i), tx_data, 8'h00);
        end
        tx_req = 1'b0;
        repeat (20) tick;
        chk("rst_no_start", start_cnt, s0);
        chk("rst_byte_num", tx_byte_num, 16'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
